traffic_phase_scheduler: RTL
============================

# traffic_phase_scheduler

Timed phase controller for a two-road intersection. It drives a main-street light head and a side-street light head, each using the 3-bit one-hot light encoding. Main street rests on green and yields to the side street only when a side-street vehicle or a pedestrian request is pending. Yellow and all-red clearance intervals are enforced between every change of right-of-way. The block sits above the light-head drivers and is the single source of phase sequencing for the intersection.

## Interface
Parameters:
- `MAIN_GREEN_MIN`, default 8: minimum main-green dwell in cycles (1..255).
- `SIDE_GREEN`, default 6: fixed side-green dwell in cycles (1..255).
- `YELLOW`, default 3: yellow dwell in cycles, applied to both heads (1..255).
- `ALL_RED`, default 1: clearance dwell in cycles, both heads red (1..255).

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `side_req`  in  1  side-street vehicle sensor, level-sensitive, not latched.
- `ped_btn`  in  1  pedestrian button; a single-cycle pulse is sufficient.
- `main_light`  out  3  main head: red=001, yellow=010, green=100.
- `side_light`  out  3  side head, same encoding.
- `walk`  out  1  pedestrian walk signal.
- `ped_pending`  out  1  a pedestrian request is latched and not yet served.
- `phase`  out  3  current state code, for debug/status.

## Operation
- States, with their `phase` codes:
  - MAIN_GREEN=0
  - MAIN_YELLOW=1
  - CLEAR_TO_SIDE=2
  - SIDE_GREEN=3
  - SIDE_YELLOW=4
  - CLEAR_TO_MAIN=5
  - Codes 6-7 are illegal and recover to MAIN_GREEN on the next edge.
- Light decode, Moore, from the state register only:
  - MAIN_GREEN: main=100, side=001.
  - MAIN_YELLOW: main=010, side=001.
  - CLEAR_*: both 001.
  - SIDE_GREEN: main=001, side=100.
  - SIDE_YELLOW: main=001, side=010.
  - The two heads are never non-red simultaneously.
- Dwell timer, 8-bit down-counter:
  - Loaded with (duration-1) on every state entry.
  - Decrements each cycle and saturates at 0.
  - `done` = counter==0.
- Transitions:
  - MAIN_GREEN → MAIN_YELLOW when done and (`side_req` or ped latch).
  - Otherwise MAIN_GREEN holds indefinitely with the counter parked at 0.
  - Every other state advances when done: MAIN_YELLOW → CLEAR_TO_SIDE → SIDE_GREEN → SIDE_YELLOW → CLEAR_TO_MAIN → MAIN_GREEN.
- Pedestrian latch:
  - Set by `ped_btn` in any state.
  - Cleared on the edge that enters SIDE_GREEN, at which point `walk_active` is set.
  - `walk` = `walk_active` and state==SIDE_GREEN.
  - `walk_active` clears on leaving SIDE_GREEN.
  - `ped_btn` high on the entering edge is consumed by that service; it does not re-latch.
  - `ped_btn` during SIDE_GREEN, SIDE_YELLOW or CLEAR_TO_MAIN re-latches and is served next cycle round.
- `ped_pending` = latch value.
- `side_req` dropping after MAIN_YELLOW has been entered does not abort the sequence.

## Timing
- Reset values:
  - state MAIN_GREEN, counter MAIN_GREEN_MIN-1, latch 0, `walk_active` 0.
  - Outputs: `main_light`=100, `side_light`=001, `walk`=0, `ped_pending`=0, `phase`=0.
- Each state lasts exactly its parameter in cycles, except MAIN_GREEN, which lasts at least MAIN_GREEN_MIN.
- Request response latency:
  - A request present in a cycle where MAIN_GREEN is done produces MAIN_YELLOW on the next cycle.
  - `ped_btn` produces `ped_pending`=1 one cycle later.
- `rst` mid-sequence, in any state, returns to the reset values on the next edge. It takes priority over every transition and over `ped_btn`.

## Structure
- Shared package `traffic_pkg` holds:
  - the light constants RED/YELLOW/GREEN (3'b001/3'b010/3'b100);
  - the 3-bit phase enum;
  - the timer width constant (8).
- Sub-module `phase_timer`:
  - Ports: `clk`, `rst`, `load`, `load_val[7:0]`, `done`.
  - Loadable saturating down-counter, instantiated once.
- The top level holds the state register, next-state logic, pedestrian latch and light decode.

## Test plan
All scenarios use default parameters.
- **Idle:** `side_req` and `ped_btn` held low for 50 cycles after `rst` → `main_light`=100, `side_light`=001 and `phase`=0 throughout.
- **Full cycle:** `side_req` held high from reset release, cycle 0 = first cycle after `rst` falls → required response:
  - MAIN_GREEN cycles 0-7, MAIN_YELLOW 8-10, CLEAR 11;
  - SIDE_GREEN 12-17, SIDE_YELLOW 18-20, CLEAR 21;
  - MAIN_GREEN at 22, then repeating the same sequence;
  - `walk`=0 throughout.
- **Late request:** one-cycle `ped_btn` pulse at cycle 30, sensor low → `ped_pending`=1 at 31, MAIN_YELLOW at 31, SIDE_GREEN at 35 with `walk`=1 for cycles 35-40, `ped_pending`=0 from 35.
- **Re-press:** `ped_btn` pulsed on the SIDE_GREEN entry edge and again mid-SIDE_GREEN → first press consumed, second press leaves `ped_pending`=1 and forces another side phase after the next MAIN_GREEN minimum.
- **Reset mid-operation:** `rst` asserted for one cycle during SIDE_YELLOW with the latch set → next cycle `main_light`=100, `side_light`=001, `ped_pending`=0, `phase`=0, and the full MAIN_GREEN minimum is re-timed.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light encodings, phase codes and timer width for the intersection controller
package traffic_pkg;
  localparam int TIMER_W = 8;
  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN = 3'b100;
  typedef enum logic [2:0] {
    PH_MAIN_GREEN = 3'd0,
    PH_MAIN_YELLOW = 3'd1,
    PH_CLEAR_TO_SIDE = 3'd2,
    PH_SIDE_GREEN = 3'd3,
    PH_SIDE_YELLOW = 3'd4,
    PH_CLEAR_TO_MAIN = 3'd5
  } phase_t;
endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// phase_timer: loadable down-counter that parks at zero; done flags zero
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);
  logic [TIMER_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: timed main/side phase sequencer with pedestrian latch and walk signal
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_MIN = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW = 3,
  parameter int ALL_RED = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_btn,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);
  phase_t state, state_nx;
  logic done, load, enter_side, leave_side, ped_latch, walk_active;
  logic [TIMER_W-1:0] load_val;
  always_ff @(posedge clk)
    if (rst) begin
      state <= PH_MAIN_GREEN;
      ped_latch <= 1'b0;
      walk_active <= 1'b0;
    end else begin
      state <= state_nx;
      ped_latch <= enter_side ? 1'b0 : ped_latch | ped_btn;
      walk_active <= enter_side ? ped_latch | ped_btn : leave_side ? 1'b0 : walk_active;
    end
  always_comb begin
    state_nx = PH_MAIN_GREEN;
    case (state)
      PH_MAIN_GREEN: state_nx = (done && (side_req || ped_btn || ped_latch)) ? PH_MAIN_YELLOW : PH_MAIN_GREEN;
      PH_MAIN_YELLOW: state_nx = done ? PH_CLEAR_TO_SIDE : PH_MAIN_YELLOW;
      PH_CLEAR_TO_SIDE: state_nx = done ? PH_SIDE_GREEN : PH_CLEAR_TO_SIDE;
      PH_SIDE_GREEN: state_nx = done ? PH_SIDE_YELLOW : PH_SIDE_GREEN;
      PH_SIDE_YELLOW: state_nx = done ? PH_CLEAR_TO_MAIN : PH_SIDE_YELLOW;
      PH_CLEAR_TO_MAIN: state_nx = done ? PH_MAIN_GREEN : PH_CLEAR_TO_MAIN;
      default: state_nx = PH_MAIN_GREEN;
    endcase
    load = state_nx != state;
    enter_side = load && state_nx == PH_SIDE_GREEN;
    leave_side = load && state == PH_SIDE_GREEN;
    load_val = (state_nx == PH_MAIN_GREEN) ? TIMER_W'(MAIN_GREEN_MIN - 1) :
               (state_nx == PH_SIDE_GREEN) ? TIMER_W'(SIDE_GREEN - 1) :
               (state_nx == PH_MAIN_YELLOW || state_nx == PH_SIDE_YELLOW) ? TIMER_W'(YELLOW - 1) :
               TIMER_W'(ALL_RED - 1);
  end
  phase_timer #(.RST_VAL(TIMER_W'(MAIN_GREEN_MIN - 1))) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .done(done)
  );
  assign main_light = (state == PH_MAIN_GREEN) ? GREEN : (state == PH_MAIN_YELLOW) ? traffic_pkg::YELLOW : RED;
  assign side_light = (state == PH_SIDE_GREEN) ? GREEN : (state == PH_SIDE_YELLOW) ? traffic_pkg::YELLOW : RED;
  assign walk = walk_active && state == PH_SIDE_GREEN;
  assign ped_pending = ped_latch;
  assign phase = state;
endmodule
